// File: rtl/reset_req_pkg.sv
// Shared state type, cause-bit layout and counter sizing helper for reset_req_gen.
// Defining RESET_REQ_SOFT_EN widens the cause field to carry the software request bit.
package reset_req_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } req_state_t;

    localparam int CAUSE_BTN = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_SW  = 2;

`ifdef RESET_REQ_SOFT_EN
    localparam int CAUSE_W = 3;
`else
    localparam int CAUSE_W = 2;
`endif

    // Bits needed to hold a counter whose largest value is 'terminal', never below 1.
    function automatic int cnt_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/reset_req_gen_btn_debounce.sv
// Pushbutton front end: SYNC_STAGES-flop synchronizer followed by a stability counter.
// btn_evt pulses for one cycle when the debounced level goes 0->1; releases are silent.
module btn_debounce
    import reset_req_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_db,
    output logic btn_evt
);

    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [DB_W-1:0]        db_cnt;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // The count only advances while the synchronized level disagrees with btn_db,
    // so it tops out at DB_LAST and never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_cnt  <= '0;
            btn_db  <= 1'b0;
            btn_evt <= 1'b0;
        end else begin
            btn_evt <= 1'b0;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt  <= '0;
                btn_db  <= btn_sync;
                btn_evt <= btn_sync;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/reset_req_gen.sv
// Reset request source: debounced pushbutton and watchdog feed a fixed-width reset_req pulse
// followed by a holdoff window. Optional software request input under RESET_REQ_SOFT_EN.
module reset_req_gen
    import reset_req_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WDT_TIMEOUT     = 1000,
    parameter int REQ_CYCLES      = 8,
    parameter int HOLDOFF_CYCLES  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_in,
    input  logic               wdt_en,
    input  logic               wdt_kick,
`ifdef RESET_REQ_SOFT_EN
    input  logic               sw_req,
`endif
    output logic               reset_req,
    output logic [CAUSE_W-1:0] req_cause,
    output logic               busy
);

    localparam int               WDT_W    = cnt_width(WDT_TIMEOUT - 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

    localparam int PH_TERM = (REQ_CYCLES > HOLDOFF_CYCLES) ? (REQ_CYCLES - 1)
                                                           : (HOLDOFF_CYCLES - 1);
    localparam int              PH_W      = cnt_width(PH_TERM);
    localparam logic [PH_W-1:0] REQ_LAST  = PH_W'(REQ_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLDOFF_CYCLES - 1);

    req_state_t         state;
    req_state_t         state_nxt;
    logic [PH_W-1:0]    phase_cnt;
    logic [PH_W-1:0]    phase_nxt;
    logic [WDT_W-1:0]   wdt_cnt;
    logic               wdt_run;
    logic               wdt_evt;
    logic               btn_db;
    logic               btn_evt;
    logic [CAUSE_W-1:0] evt_vec;
    logic               any_evt;
    logic               reset_req_nxt;
    logic               busy_nxt;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_in (btn_in),
        .btn_db (btn_db),
        .btn_evt(btn_evt)
    );

    // Watchdog only counts quiet IDLE cycles; a kick on the terminal cycle suppresses the event.
    assign wdt_run = wdt_en && !wdt_kick && (state == IDLE);
    assign wdt_evt = wdt_run && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n || !wdt_run || wdt_evt) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    always_comb begin
        evt_vec            = '0;
        evt_vec[CAUSE_BTN] = btn_evt & btn_db;
        evt_vec[CAUSE_WDT] = wdt_evt;
`ifdef RESET_REQ_SOFT_EN
        evt_vec[CAUSE_SW]  = sw_req;
`endif
    end

    assign any_evt = |evt_vec;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        case (state)
            IDLE: begin
                if (any_evt) begin
                    state_nxt = ASSERT;
                    phase_nxt = '0;
                end
            end
            ASSERT: begin
                if (phase_cnt == REQ_LAST) begin
                    state_nxt = HOLDOFF;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_W'(1);
                end
            end
            HOLDOFF: begin
                if (phase_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + PH_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track state exactly.
    always_comb begin
        reset_req_nxt = (state_nxt == ASSERT);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reset_req <= 1'b0;
            busy      <= 1'b0;
            req_cause <= '0;
        end else begin
            reset_req <= reset_req_nxt;
            busy      <= busy_nxt;
            if ((state == IDLE) && any_evt) begin
                req_cause <= evt_vec;
            end
        end
    end

endmodule
